// File: rtl/histo_bin_accum.sv
// Histogram bin memory with pipelined read-modify-write increment,
// hazard forwarding, sequential clear and read(-and-clear) readout.
module histo_bin_accum #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 24,
    parameter bit SATURATE = 1'b1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_clock_en,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_inc_addr,
    input  logic              i_clear,
    input  logic              i_read_en,
    input  logic              i_read_clr,
    input  logic [ADDR_W-1:0] i_read_addr,
    output logic              o_read_ack,
    output logic              o_read_valid,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_busy,
    output logic              o_overflow,
    output logic              o_dropped
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    logic              r_busy;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_p1_vld;
    logic [ADDR_W-1:0] r_p1_addr;
    logic              r_fwd_vld;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;
    logic              r_clr_pend;
    logic [ADDR_W-1:0] r_clr_pend_addr;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_rd_hold;
    logic              r_ovf;
    logic              r_drop;

    logic              w_inc_acc;
    logic              w_read_ack;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W:0]   w_sum;
    logic              w_carry;
    logic [DATA_W-1:0] w_new;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_inc_acc  = i_clock_en & i_inc & ~r_busy;
    assign w_read_ack = i_clock_en & i_read_en & ~i_inc & ~r_busy
                        & ~r_p1_vld & ~r_clr_pend;
    assign w_raddr    = i_inc ? i_inc_addr : i_read_addr;

    // RAM is read-first, so a write in the previous cycle must be forwarded
    assign w_base  = (r_fwd_vld && (r_fwd_addr == r_p1_addr)) ? r_fwd_data : r_q;
    assign w_sum   = {1'b0, w_base} + {{DATA_W{1'b0}}, 1'b1};
    assign w_carry = w_sum[DATA_W];
    assign w_new   = (SATURATE && w_carry) ? w_base : w_sum[DATA_W-1:0];

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_p1_addr;
        w_wdata = '0;
        if (r_busy) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
        end else if (r_p1_vld) begin
            w_we    = 1'b1;
            w_wdata = w_new;
        end else if (r_clr_pend) begin
            w_we    = 1'b1;
            w_waddr = r_clr_pend_addr;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_clock_en) begin
            if (w_we && !i_reset) r_mem[w_waddr] <= w_wdata;
            r_q <= r_mem[w_raddr];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_busy          <= 1'b1;
            r_clr_addr      <= '0;
            r_p1_vld        <= 1'b0;
            r_p1_addr       <= '0;
            r_fwd_vld       <= 1'b0;
            r_fwd_addr      <= '0;
            r_fwd_data      <= '0;
            r_clr_pend      <= 1'b0;
            r_clr_pend_addr <= '0;
            r_rd_vld        <= 1'b0;
            r_rd_hold       <= '0;
            r_ovf           <= 1'b0;
            r_drop          <= 1'b0;
        end else if (i_clock_en) begin
            r_p1_vld <= w_inc_acc;
            if (w_inc_acc) r_p1_addr <= i_inc_addr;
            r_clr_pend <= w_read_ack & i_read_clr;
            if (w_read_ack) r_clr_pend_addr <= i_read_addr;
            r_rd_vld <= w_read_ack;
            if (r_rd_vld) r_rd_hold <= r_q;
            r_fwd_vld <= 1'b0;
            if (!r_busy && r_p1_vld) begin
                r_fwd_vld  <= 1'b1;
                r_fwd_addr <= r_p1_addr;
                r_fwd_data <= w_new;
                if (w_carry) r_ovf <= 1'b1;
            end else if (!r_busy && r_clr_pend) begin
                r_fwd_vld  <= 1'b1;
                r_fwd_addr <= r_clr_pend_addr;
                r_fwd_data <= '0;
            end
            if (i_inc && r_busy) r_drop <= 1'b1;
            if (r_busy) begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
                if (&r_clr_addr) r_busy <= 1'b0;
            end
            // Work in flight is moot: every bin is about to be zeroed
            if (i_clear) begin
                r_busy     <= 1'b1;
                r_clr_addr <= '0;
                r_p1_vld   <= 1'b0;
                r_fwd_vld  <= 1'b0;
                r_clr_pend <= 1'b0;
                r_ovf      <= 1'b0;
                r_drop     <= 1'b0;
            end
        end
    end

    assign o_read_ack   = w_read_ack;
    assign o_read_valid = r_rd_vld;
    assign o_read_data  = r_rd_vld ? r_q : r_rd_hold;
    assign o_busy       = r_busy;
    assign o_overflow   = r_ovf;
    assign o_dropped    = r_drop;

endmodule
